// File: rtl/rx_sym_align.sv
// rx_sym_align -- receive-side symbol alignment and decimation stage.
//
// Purpose:
//   Sits after the receive matched filter in the sample-rate domain. A
//   selectable-depth delay line aligns the sample stream, an integer
//   decimator with programmable phase picks one sample in 2^LOG2_DECIM, and
//   the symbol strobe is blanked while a new alignment setting flushes
//   through the delay line.
//
// Parameters:
//   WIDTH       sample width (signed two's complement)
//   DEPTH       delay-line registers, i.e. maximum selectable delay
//   SEL_W       width of delay_sel, 2^SEL_W > DEPTH
//   LOG2_DECIM  decimation factor is 2^LOG2_DECIM (0 = no decimation)
//   ACC_W       energy accumulator headroom bits (energy option only)
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   sam_clk      sample-rate clock enable, one clk wide
//   x_in         signed input sample, valid with sam_clk
//   delay_sel    delay in sample periods, 0..DEPTH (larger values clamp)
//   phase        decimation phase
//   data_out     signed decimated, aligned sample
//   sym_valid    one-cycle strobe: data_out is a new qualified symbol
//   settling     high while an alignment change is being flushed
//   clear_accum  synchronous clear of the energy accumulator (option)
//   energy       saturating sum of |data_out| over qualified symbols (option)
//
// Build option:
//   RX_ALIGN_ENERGY_EN  adds the clear_accum / energy symbol-energy
//                       accumulator. Undefined by default.

module rx_sym_align #(
  parameter int WIDTH      = 18,
  parameter int DEPTH      = 8,
  parameter int SEL_W      = 4,
  parameter int LOG2_DECIM = 2,
  parameter int ACC_W      = 8,
  localparam int PH_W      = (LOG2_DECIM > 0) ? LOG2_DECIM : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sam_clk,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic [SEL_W-1:0]        delay_sel,
  input  logic [PH_W-1:0]         phase,
`ifdef RX_ALIGN_ENERGY_EN
  input  logic                    clear_accum,
`endif
  output logic signed [WIDTH-1:0] data_out,
  output logic                    sym_valid,
`ifdef RX_ALIGN_ENERGY_EN
  output logic [WIDTH+ACC_W-1:0]  energy,
`endif
  output logic                    settling
);

  localparam int TAPS = (DEPTH > 0) ? DEPTH : 1;
  localparam int SC_W = (DEPTH > 0) ? $clog2(DEPTH + 1) : 1;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_SETTLE = 1'b1
  } state_t;

  logic signed [WIDTH-1:0] tap_q [TAPS];
  logic [SEL_W-1:0]        sel_eff_d;
  logic signed [WIDTH-1:0] sel_s_d;
  logic [PH_W-1:0]         cnt_q;
  logic                    pick_d;
  logic                    change_d;

  logic [SEL_W-1:0]        sel_q;
  logic [PH_W-1:0]         phase_q;
  state_t                  state_q;
  logic [SC_W-1:0]         scnt_q;
  logic                    settling_q;
  logic signed [WIDTH-1:0] data_out_q;
  logic                    sym_valid_q;

  // ---------------------------------------------------------------------
  // Delay line: shifts once per sample enable.
  // ---------------------------------------------------------------------
  if (DEPTH > 0) begin : g_taps
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_tap
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          tap_q[gi] <= '0;
        end else if (sam_clk) begin
          if (gi == 0) tap_q[gi] <= x_in;
          else         tap_q[gi] <= tap_q[(gi > 0) ? gi - 1 : 0];
        end
      end
    end
  end else begin : g_no_taps
    assign tap_q[0] = '0;
  end

  // Out-of-range selections clamp to the deepest tap.
  always_comb begin
    sel_eff_d = (delay_sel > SEL_W'(DEPTH)) ? SEL_W'(DEPTH) : delay_sel;
    sel_s_d   = x_in;
    for (int k = 1; k <= DEPTH; k++) begin
      if (sel_eff_d == SEL_W'(k)) sel_s_d = tap_q[k-1];
    end
  end

  // ---------------------------------------------------------------------
  // Decimation counter and pick qualifier. Without decimation every
  // sample enable is a pick and the counter stays at zero.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (sam_clk && (LOG2_DECIM > 0)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign pick_d   = sam_clk && ((LOG2_DECIM == 0) || (cnt_q == phase));
  assign change_d = (delay_sel != sel_q) || (phase != phase_q);

  // ---------------------------------------------------------------------
  // Settle FSM. A change always wins over a sample-enable decrement so the
  // flush window restarts from the full depth.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_q      <= '0;
      phase_q    <= '0;
      state_q    <= ST_SETTLE;
      scnt_q     <= SC_W'(DEPTH);
      settling_q <= 1'b1;
    end else begin
      sel_q   <= delay_sel;
      phase_q <= phase;
      if (change_d) begin
        state_q    <= ST_SETTLE;
        scnt_q     <= SC_W'(DEPTH);
        settling_q <= 1'b1;
      end else if (state_q == ST_SETTLE) begin
        if (scnt_q == '0) begin
          // Zero-depth line: nothing to flush.
          state_q    <= ST_RUN;
          settling_q <= 1'b0;
        end else if (sam_clk) begin
          scnt_q <= scnt_q - 1'b1;
          if (scnt_q == SC_W'(1)) begin
            state_q    <= ST_RUN;
            settling_q <= 1'b0;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Output register. data_out follows every pick, qualified or not; the
  // strobe is suppressed while settling or when a change lands on the pick.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out_q  <= '0;
      sym_valid_q <= 1'b0;
    end else begin
      if (pick_d) data_out_q <= sel_s_d;
      sym_valid_q <= pick_d && (state_q == ST_RUN) && !change_d;
    end
  end

  assign data_out  = data_out_q;
  assign sym_valid = sym_valid_q;
  assign settling  = settling_q;

`ifdef RX_ALIGN_ENERGY_EN
  // ---------------------------------------------------------------------
  // Symbol-energy accumulator: saturating sum of |data_out|. The magnitude
  // of the most negative sample fits in WIDTH unsigned bits.
  // ---------------------------------------------------------------------
  localparam int E_W = WIDTH + ACC_W;

  logic [E_W-1:0]   energy_q;
  logic [WIDTH-1:0] mag_d;
  logic [E_W:0]     sum_d;

  always_comb begin
    mag_d = data_out_q[WIDTH-1] ? (~$unsigned(data_out_q) + 1'b1)
                                : $unsigned(data_out_q);
    sum_d = {1'b0, energy_q} + (E_W + 1)'(mag_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      energy_q <= '0;
    end else if (clear_accum) begin
      energy_q <= '0;
    end else if (sym_valid_q) begin
      energy_q <= sum_d[E_W] ? {E_W{1'b1}} : sum_d[E_W-1:0];
    end
  end

  assign energy = energy_q;
`endif

endmodule

// File: tb/tb_rx_sym_align.sv
// Directed bench for rx_sym_align. Two instances share clock, reset, sample
// stream and delay select: u_dut0 has no decimation, u_dut4 decimates by 4.
// The energy checks are built only when RX_ALIGN_ENERGY_EN is defined.

module tb_rx_sym_align;

  localparam int W  = 18;
  localparam int D  = 8;
  localparam int SW = 4;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                sam_clk = 1'b0;
  logic signed [W-1:0] x_in = '0;
  logic [SW-1:0]       delay_sel = '0;
  logic [0:0]          phase0 = '0;
  logic [1:0]          phase4 = '0;
  logic signed [W-1:0] dout0, dout4;
  logic                sv0, sv4, st0, st4;
`ifdef RX_ALIGN_ENERGY_EN
  logic                clear_accum = 1'b0;
  logic [W+8-1:0]      en0, en4;
`endif

  int checks = 0;
  int errors = 0;
  int nsam   = 0;
  int rv     = 1;
  bit verbose = 1'b1;
  logic signed [W-1:0] xs[$];

  always #5 clk = ~clk;

  rx_sym_align #(.WIDTH(W), .DEPTH(D), .SEL_W(SW), .LOG2_DECIM(0), .ACC_W(8)) u_dut0 (
    .clk(clk), .reset(reset), .sam_clk(sam_clk), .x_in(x_in),
    .delay_sel(delay_sel), .phase(phase0),
`ifdef RX_ALIGN_ENERGY_EN
    .clear_accum(clear_accum), .energy(en0),
`endif
    .data_out(dout0), .sym_valid(sv0), .settling(st0)
  );

  rx_sym_align #(.WIDTH(W), .DEPTH(D), .SEL_W(SW), .LOG2_DECIM(2), .ACC_W(8)) u_dut4 (
    .clk(clk), .reset(reset), .sam_clk(sam_clk), .x_in(x_in),
    .delay_sel(delay_sel), .phase(phase4),
`ifdef RX_ALIGN_ENERGY_EN
    .clear_accum(clear_accum), .energy(en4),
`endif
    .data_out(dout4), .sym_valid(sv4), .settling(st4)
  );

  // Expected selected sample: the input d enables before the current one,
  // with selections beyond the line depth clamped to the deepest tap.
  function automatic logic signed [W-1:0] exp_sel(input int d);
    int dd;
    int i;
    dd = (d > D) ? D : d;
    i  = xs.size() - 1 - dd;
    return (i >= 0) ? xs[i] : '0;
  endfunction

  // One sample enable; outputs are sampled 1 ns after the edge ending it.
  task automatic sam(input logic signed [W-1:0] x);
    @(negedge clk);
    sam_clk = 1'b1;
    x_in    = x;
    @(posedge clk);
    #1;
    sam_clk = 1'b0;
    xs.push_back(x);
    nsam++;
    if (verbose)
      $display("sam %0d x=%0d sel=%0d | d0=%0d v0=%b s0=%b | d4=%0d v4=%b s4=%b",
               nsam, x, delay_sel, dout0, sv0, st0, dout4, sv4, st4);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_sel(input logic [SW-1:0] s);
    @(negedge clk);
    delay_sel = s;
    idle(1);
  endtask

  task automatic test_reset();
    logic e;
    for (int k = 0; k < 5; k++) sam(W'(100 + k));
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++; if (dout0 !== '0) begin errors++; $display("FAIL reset_dout0: got %0d expected 0", dout0); end
    checks++; if (dout4 !== '0) begin errors++; $display("FAIL reset_dout4: got %0d expected 0", dout4); end
    checks++; if (sv0 !== 1'b0 || sv4 !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b%b expected 00", sv0, sv4); end
    checks++; if (st0 !== 1'b1 || st4 !== 1'b1) begin errors++; $display("FAIL reset_settling: got %b%b expected 11", st0, st4); end
    delay_sel = '0; phase0 = '0; phase4 = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    xs.delete(); nsam = 0;
    for (int k = 1; k <= 12; k++) begin
      sam(W'(k * 7));
      checks++; if (sv0 !== (k >= 9)) begin errors++; $display("FAIL rel_sv0 k=%0d: got %b expected %b", k, sv0, (k >= 9)); end
      checks++; if (st0 !== (k < 8)) begin errors++; $display("FAIL rel_st0 k=%0d: got %b expected %b", k, st0, (k < 8)); end
      checks++; if (dout0 !== W'(k * 7)) begin errors++; $display("FAIL rel_dout0 k=%0d: got %0d expected %0d", k, dout0, k * 7); end
      e = ((k - 1) % 4 == 0) && (k >= 9);
      checks++; if (sv4 !== e) begin errors++; $display("FAIL rel_sv4 k=%0d: got %b expected %b", k, sv4, e); end
    end
  endtask

  task automatic test_delay();
    set_sel(4'd3);
    for (int k = 1; k <= 12; k++) begin
      sam(W'(rv)); rv++;
      checks++; if (dout0 !== exp_sel(3)) begin errors++; $display("FAIL delay3_dout k=%0d: got %0d expected %0d", k, dout0, exp_sel(3)); end
      checks++; if (sv0 !== (k >= 9)) begin errors++; $display("FAIL delay3_sv k=%0d: got %b expected %b", k, sv0, (k >= 9)); end
    end
    set_sel(4'd12);
    for (int k = 1; k <= 12; k++) begin
      sam(W'(rv)); rv++;
      checks++; if (dout0 !== exp_sel(12)) begin errors++; $display("FAIL delay12_dout k=%0d: got %0d expected %0d", k, dout0, exp_sel(12)); end
    end
  endtask

  task automatic test_phase();
    logic signed [W-1:0] last4;
    logic e;
    @(negedge clk);
    reset = 1'b0;
    delay_sel = '0; phase4 = 2'd2;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    xs.delete(); nsam = 0;
    idle(1);
    last4 = '0;
    for (int k = 0; k < 24; k++) begin
      sam(W'(k));
      if (k % 4 == 2) last4 = W'(k);
      e = (k % 4 == 2) && (k >= 8);
      checks++; if (sv4 !== e) begin errors++; $display("FAIL phase_sv4 k=%0d: got %b expected %b", k, sv4, e); end
      checks++; if (dout4 !== last4) begin errors++; $display("FAIL phase_dout4 k=%0d: got %0d expected %0d", k, dout4, last4); end
    end
  endtask

  task automatic test_settle();
    set_sel(4'd1);
    for (int k = 1; k <= 10; k++) begin sam(W'(rv)); rv++; end
    checks++; if (sv0 !== 1'b1 || dout0 !== exp_sel(1)) begin errors++; $display("FAIL settle_run: got v=%b d=%0d expected v=1 d=%0d", sv0, dout0, exp_sel(1)); end
    set_sel(4'd5);
    for (int k = 1; k <= 4; k++) begin
      sam(W'(rv)); rv++;
      checks++; if (sv0 !== 1'b0 || st0 !== 1'b1) begin errors++; $display("FAIL settle_win1 k=%0d: got v=%b s=%b expected v=0 s=1", k, sv0, st0); end
    end
    set_sel(4'd2);
    for (int k = 1; k <= 9; k++) begin
      sam(W'(rv)); rv++;
      checks++; if (sv0 !== (k == 9)) begin errors++; $display("FAIL settle_win2_sv k=%0d: got %b expected %b", k, sv0, (k == 9)); end
      checks++; if (st0 !== (k < 8)) begin errors++; $display("FAIL settle_win2_st k=%0d: got %b expected %b", k, st0, (k < 8)); end
      checks++; if (dout0 !== exp_sel(2)) begin errors++; $display("FAIL settle_dout k=%0d: got %0d expected %0d", k, dout0, exp_sel(2)); end
    end
  endtask

  task automatic test_simultaneous();
    logic signed [W-1:0] held;
    for (int k = 0; k < 4; k++) begin sam(W'(rv)); rv++; end
    while (nsam % 4 != 1) begin sam(W'(rv)); rv++; end
    checks++; if (st4 !== 1'b0) begin errors++; $display("FAIL simul_pre_st4: got %b expected 0", st4); end
    // Phase change lands on a cycle that is a pick under the new phase.
    @(negedge clk);
    phase4  = 2'd1;
    sam_clk = 1'b1;
    x_in    = W'(rv);
    @(posedge clk);
    #1;
    sam_clk = 1'b0;
    xs.push_back(W'(rv)); nsam++; rv++;
    $display("simul x=%0d | d4=%0d v4=%b s4=%b", xs[$], dout4, sv4, st4);
    checks++; if (dout4 !== exp_sel(2)) begin errors++; $display("FAIL simul_dout4: got %0d expected %0d", dout4, exp_sel(2)); end
    checks++; if (sv4 !== 1'b0) begin errors++; $display("FAIL simul_sv4: got %b expected 0", sv4); end
    checks++; if (st4 !== 1'b1) begin errors++; $display("FAIL simul_st4: got %b expected 1", st4); end
    for (int k = 1; k <= 12; k++) begin
      sam(W'(rv)); rv++;
      checks++; if (sv4 !== (k == 12)) begin errors++; $display("FAIL simul_after_sv4 k=%0d: got %b expected %b", k, sv4, (k == 12)); end
    end
    held = exp_sel(2);
    idle(1);
    checks++; if (sv4 !== 1'b0 || dout4 !== held) begin errors++; $display("FAIL pulse_width: got v=%b d=%0d expected v=0 d=%0d", sv4, dout4, held); end
  endtask

`ifdef RX_ALIGN_ENERGY_EN
  task automatic test_energy();
    logic [W+8-1:0] e;
    set_sel(4'd0);
    for (int k = 0; k < 10; k++) sam('0);
    @(negedge clk); clear_accum = 1'b1;
    @(posedge clk); #1; clear_accum = 1'b0;
    checks++; if (en0 !== '0) begin errors++; $display("FAIL energy_clear: got %0d expected 0", en0); end
    sam(W'(100)); sam(-W'(100)); sam(-W'(131072));
    idle(2);
    checks++; if (en0 !== 26'd131272) begin errors++; $display("FAIL energy_sum: got %0d expected 131272", en0); end
    sam(W'(500));
    checks++; if (sv0 !== 1'b1) begin errors++; $display("FAIL energy_sv: got %b expected 1", sv0); end
    @(negedge clk); clear_accum = 1'b1;
    @(posedge clk); #1; clear_accum = 1'b0;
    idle(1);
    checks++; if (en0 !== '0) begin errors++; $display("FAIL energy_clear_prio: got %0d expected 0", en0); end
    verbose = 1'b0;
    for (int k = 0; k < 511; k++) sam(-W'(131072));
    idle(2);
    e = 26'd66977792;
    checks++; if (en0 !== e) begin errors++; $display("FAIL energy_near_sat: got %0d expected %0d", en0, e); end
    for (int k = 0; k < 9; k++) sam(-W'(131072));
    idle(2);
    e = '1;
    checks++; if (en0 !== e) begin errors++; $display("FAIL energy_sat: got %0d expected %0d", en0, e); end
    verbose = 1'b1;
  endtask
`endif

  initial begin
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    test_reset();
    test_delay();
    test_phase();
    test_settle();
    test_simultaneous();
`ifdef RX_ALIGN_ENERGY_EN
    test_energy();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_sym_align.md
# rx_sym_align

Parametrised receive-side symbol alignment and decimation stage. It sits after the receive matched filter in the sample-rate domain and provides:
- a selectable-depth sample delay line for timing alignment;
- an integer decimator with programmable sampling phase;
- automatic output blanking while a new alignment setting flushes through.

It replaces the fixed four-tap, switch-selected delay and fixed ÷4 down-sampler pair with one configurable block that produces a qualified symbol stream.

## Interface
Parameters:
- WIDTH, 18: sample width, signed two's complement.
- DEPTH, 8: number of delay-line registers; maximum selectable delay.
- SEL_W, 4: width of delay_sel; must satisfy 2^SEL_W > DEPTH.
- LOG2_DECIM, 2: decimation factor is 2^LOG2_DECIM; 0 means no decimation.
- ACC_W, 8: extra accumulator headroom bits; only used with RX_ALIGN_ENERGY_EN.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- sam_clk  in  1  sample-rate clock enable, one clk cycle wide.
- x_in  in  WIDTH  signed input sample; valid when sam_clk=1.
- delay_sel  in  SEL_W  delay in sample periods, 0..DEPTH.
- phase  in  max(LOG2_DECIM,1)  decimation phase.
- data_out  out  WIDTH  signed decimated, aligned sample.
- sym_valid  out  1  one-cycle strobe; data_out is a new qualified symbol.
- settling  out  1  high while the alignment change is being flushed.

## Operation
Delay line:
- On each sam_clk: tap[0]<=x_in, tap[k]<=tap[k-1] for k=1..DEPTH-1.
- Selected sample sel_s = x_in when delay_sel=0, else tap[delay_sel-1].
- delay_sel>DEPTH clamps to DEPTH.

Decimation counter:
- cnt is LOG2_DECIM bits wide, increments on each sam_clk and wraps at 2^LOG2_DECIM-1 → 0.
- A pick occurs on a sam_clk cycle where cnt==phase. With LOG2_DECIM=0, every sam_clk is a pick.

Output on a pick:
- data_out <= sel_s.
- sym_valid <= 1 if state is RUN, else 0.
- On any cycle that is not a pick, sym_valid <= 0 and data_out holds.

Settle state machine, states RUN and SETTLE, with settle counter scnt of width clog2(DEPTH+1):
- sel_q and phase_q register delay_sel and phase every clk.
- A change is detected when delay_sel!=sel_q or phase!=phase_q.
- Any state + change → SETTLE, scnt<=DEPTH. A change during SETTLE reloads the counter.
- SETTLE: scnt decrements on sam_clk. On a sam_clk where scnt==1 and no change → RUN.
- DEPTH=0 or scnt==0 → RUN on the next clk.
- settling = (state==SETTLE), registered.
- A change and a sam_clk in the same cycle: the change wins (reload), and the pick still updates data_out.

Reset (asynchronous, reset=0):
- taps=0, cnt=0, data_out=0, sym_valid=0.
- state=SETTLE, scnt=DEPTH, settling=1.
- sel_q=0, phase_q=0.
- Asserting reset mid-operation returns immediately to these values.

## Timing
- Delay: with delay_sel=d, the data_out value equals the x_in presented d sam_clk enables before the pick cycle.
- Register latency: data_out and sym_valid update on the clk edge that ends the pick cycle (1 clk).
- sym_valid is high for exactly 1 clk, at most once per 2^LOG2_DECIM sam_clk enables.
- After reset deassertion, the first sym_valid comes on the first pick after DEPTH sam_clk enables.
- After a change, sym_valid stays 0 until DEPTH sam_clk enables pass with no further change.
- sam_clk back-to-back on consecutive clk cycles is legal.

## Configuration
RX_ALIGN_ENERGY_EN adds a symbol-energy accumulator.

When defined:
- Extra port clear_accum  in  1: synchronous clear.
- Extra port energy  out  WIDTH+ACC_W: unsigned accumulated magnitude.
- On each sym_valid=1 cycle, energy <= energy + |data_out|. |−2^(WIDTH-1)| = 2^(WIDTH-1).
- energy saturates at all-ones and never wraps.
- clear_accum has priority over accumulation in the same cycle.
- Reset value of energy is 0.

When undefined: these ports and all related logic are absent, and behaviour is otherwise identical.

## Test plan
- Reset: hold reset=0 mid-stream → all outputs 0, settling=1. Release → first sym_valid after 8 sam_clk enables (DEPTH=8).
- Delay sweep: ramp x_in=1,2,3… on every sam_clk, LOG2_DECIM=0, delay_sel=3 → after settle, data_out=n-3 on each pick; delay_sel=12 behaves as 8.
- Phase: DECIM=4, ramp input, delay_sel=0, phase=2 → sym_valid every 4th sam_clk; data_out=2,6,10….
- Settle: change delay_sel 1→5 in RUN → settling=1 and no sym_valid for 8 sam_clk enables. Change again at enable 4 → window restarts for 8 enables.
- Simultaneous: phase change on a pick cycle → data_out updates, sym_valid=0, SETTLE entered.
- Energy (macro on): symbols +100, −100, −131072 → energy=131272. Then clear_accum together with sym_valid → energy=0. Feeding full-scale symbols must saturate the accumulator at all-ones.
